// File: rtl/uart_tx_drain.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends it as 8N1.
// Define UART_TX_PARITY_EN to add an even-parity bit, which gives 8E1 frames.
module uart_tx_drain #(
  parameter int B       = 8,
  parameter int DVSR    = 27,
  parameter int SB_TICK = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         empty,
  input  logic [B-1:0] r_data,
  output logic         rd,
  output logic         tx,
  output logic         tx_busy
);

  localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int NW = (B > 1) ? $clog2(B) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(B - 1);
  localparam logic [4:0]    S_LAST    = 5'd15;
  localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt, tick_cnt_next;
  logic [4:0]    s, s_next;
  logic [NW-1:0] n, n_next;
  logic [B-1:0]  shift, shift_next;
  logic          tx_next;
  logic          tick;
`ifdef UART_TX_PARITY_EN
  logic          par, par_next;
`endif

  assign tick    = (tick_cnt == TICK_LAST);
  assign tx_busy = (state != IDLE);

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    rd         = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif
    case (state)
      IDLE: begin
        // reset_n gates the pop so that holding reset never drains the fifo
        if (!empty && reset_n) begin
          rd         = 1'b1;
          shift_next = r_data;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
`ifdef UART_TX_PARITY_EN
          par_next   = ^r_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            shift_next = shift >> 1;
            if (n == N_LAST) begin
              n_next = '0;
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + NW'(1);
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        s_next     = '0;
        n_next     = '0;
      end
    endcase

    // Divider rests at zero in IDLE so every frame starts on a clean tick grid
    if (state == IDLE || tick) begin
      tick_cnt_next = '0;
    end else begin
      tick_cnt_next = tick_cnt + TW'(1);
    end

    // Line level is derived from the upcoming state so tx is a clean flop output
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      s        <= '0;
      n        <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      s        <= s_next;
      n        <= n_next;
      shift    <= shift_next;
      tx       <= tx_next;
`ifdef UART_TX_PARITY_EN
      par      <= par_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: a cycle-level line model built from frame rules,
// plus an independent mid-bit decoder and rd-spacing checks. Honours UART_TX_PARITY_EN.
module tb_uart_tx_drain;

  localparam int B       = 8;
  localparam int DVSR    = 2;
  localparam int SB_TICK = 16;
  localparam int BIT_CLK = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CLK = BIT_CLK * (B + 2) + SB_TICK * DVSR;
`else
  localparam int FRAME_CLK = BIT_CLK * (B + 1) + SB_TICK * DVSR;
`endif

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         empty   = 1'b1;
  logic [B-1:0] r_data  = '0;
  logic         rd, tx, tx_busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  logic [B-1:0] fifo[$];
  logic [B-1:0] exp_bytes[$];
  bit           sched[$];
  bit           cap[$];
  int           rd_cycles[$];
  bit           capture     = 1'b0;
  bit           pop_pending = 1'b0;

  uart_tx_drain #(.B(B), .DVSR(DVSR), .SB_TICK(SB_TICK)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .empty(empty),
    .r_data(r_data),
    .rd(rd),
    .tx(tx),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp_v, cycle);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Expected line levels for one whole frame, one entry per clock
  task automatic schedule_frame(input logic [B-1:0] val);
    for (int i = 0; i < BIT_CLK; i++) sched.push_back(1'b0);
    for (int b = 0; b < B; b++)
      for (int i = 0; i < BIT_CLK; i++) sched.push_back(val[b]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < BIT_CLK; i++) sched.push_back(^val);
`endif
    for (int i = 0; i < SB_TICK * DVSR; i++) sched.push_back(1'b1);
  endtask

  task automatic checkOutput();
    bit busy_e, tx_e, rd_e;
    busy_e = (sched.size() != 0);
    tx_e   = busy_e ? sched[0] : 1'b1;
    rd_e   = !busy_e && !empty && reset_n;
    check("rd", rd, rd_e);
    check("tx", tx, tx_e);
    check("tx_busy", tx_busy, busy_e);
    if (capture) cap.push_back(tx);
    if (rd === 1'b1) rd_cycles.push_back(cycle);
    if (busy_e) void'(sched.pop_front());
    pop_pending = rd_e;
    if (rd_e) schedule_frame(r_data);
  endtask

  task automatic loadFifo();
    pop_pending = 1'b0;
    empty  = (fifo.size() == 0);
    r_data = empty ? B'($urandom) : fifo[0];
  endtask

  // mode 0: drive from fifo queue, 1: random empty/r_data noise, 2: empty held high
  task automatic applyStimulus(input int mode_v, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      checkOutput();
      cycle++;
      @(posedge clk);
      #1;
      case (mode_v)
        0: begin
          if (pop_pending && fifo.size() != 0) void'(fifo.pop_front());
          pop_pending = 1'b0;
          empty  = (fifo.size() == 0);
          r_data = empty ? B'($urandom) : fifo[0];
        end
        1: begin
          empty  = ($urandom_range(0, 3) != 0);
          r_data = B'($urandom);
        end
        default: begin
          empty  = 1'b1;
          r_data = B'($urandom);
        end
      endcase
    end
  endtask

  // Independent receiver: find start edges in the captured line, sample each data bit mid-way
  task automatic decodeCheck(input string tag);
    logic [B-1:0] got[$];
    logic [B-1:0] v;
    int i;
    i = 0;
    while (i < cap.size()) begin
      if (cap[i] == 1'b0) begin
        if (i + FRAME_CLK > cap.size()) break;
        v = '0;
        for (int j = 0; j < B; j++) v[j] = cap[i + BIT_CLK * (j + 1) + BIT_CLK / 2];
        got.push_back(v);
        i += FRAME_CLK;
      end else begin
        i++;
      end
    end
    check_int({tag, "_count"}, got.size(), exp_bytes.size());
    for (int k = 0; k < got.size() && k < exp_bytes.size(); k++)
      check_int($sformatf("%s_byte%0d", tag, k), int'(got[k]), int'(exp_bytes[k]));
    cap.delete();
  endtask

  task automatic spacingCheck(input string tag, input int npulses);
    check_int({tag, "_pulses"}, rd_cycles.size(), npulses);
    for (int k = 1; k < rd_cycles.size(); k++)
      check_int($sformatf("%s_gap%0d", tag, k), rd_cycles[k] - rd_cycles[k-1], FRAME_CLK + 1);
  endtask

  initial begin
    // Reset state while reset_n is low
    applyStimulus(2, 3);
    reset_n = 1'b1;

    // Empty fifo for a long stretch: the line must stay idle
    applyStimulus(2, 1000);

    // Single 0xA5 frame
    fifo = {8'hA5};
    exp_bytes = {8'hA5};
    loadFifo();
    rd_cycles.delete();
    capture = 1'b1;
    applyStimulus(0, FRAME_CLK + 20);
    capture = 1'b0;
    decodeCheck("a5");
    spacingCheck("a5", 1);

    // Three queued bytes back to back
    fifo = {8'h00, 8'hFF, 8'h55};
    exp_bytes = {8'h00, 8'hFF, 8'h55};
    loadFifo();
    rd_cycles.delete();
    capture = 1'b1;
    applyStimulus(0, 3 * (FRAME_CLK + 1) + 20);
    capture = 1'b0;
    decodeCheck("three");
    spacingCheck("three", 3);

    // Parity-relevant pattern (odd popcount)
    fifo = {8'h07, 8'h07};
    exp_bytes = {8'h07, 8'h07};
    loadFifo();
    rd_cycles.delete();
    capture = 1'b1;
    applyStimulus(0, 2 * (FRAME_CLK + 1) + 20);
    capture = 1'b0;
    decodeCheck("x07");
    spacingCheck("x07", 2);

    // Random bytes through the fifo
    fifo.delete();
    for (int k = 0; k < 4; k++) fifo.push_back(B'($urandom));
    loadFifo();
    applyStimulus(0, 4 * (FRAME_CLK + 1) + 20);

    // r_data and empty churn while frames are in flight
    applyStimulus(1, 2000);
    applyStimulus(2, FRAME_CLK + 5);

    // Reset in the middle of a frame with data still waiting
    fifo = {8'h3C, 8'hC3};
    loadFifo();
    applyStimulus(0, 150);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_tx", tx, 1'b1);
    check("rst_async_rd", rd, 1'b0);
    check("rst_async_busy", tx_busy, 1'b0);
    sched.delete();
    pop_pending = 1'b0;
    applyStimulus(0, 5);
    fifo.delete();
    loadFifo();
    reset_n = 1'b1;
    applyStimulus(0, 40);

    // Recovery after reset
    fifo = {8'hC3};
    loadFifo();
    applyStimulus(0, FRAME_CLK + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
